// File: rtl/mem_write_checker.sv
// Self-check monitor: matches core memory writes against a loadable {addr,data} table; MEMCHK_CAPTURE_EN adds fail_addr/fail_data.
// Results register one cycle after the sampled write; passive observer, never stalls the core.
module mem_write_checker #(
  parameter int          NUM_CHECKS     = 4,
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter bit          IN_ORDER       = 1'b1,
  localparam int         IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int         CNT_W          = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [31:0]       cycle_cnt
`ifdef MEMCHK_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]     ent_addr [NUM_CHECKS];
  logic [DATA_W-1:0]     ent_data [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] ent_valid;
  logic [NUM_CHECKS-1:0] ent_matched;

  logic [CNT_W-1:0] valid_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             data_ok;
  logic             match_now;
  logic             mism_now;
  logic             all_done;
  logic             tmo_now;
  logic [31:0]      cyc_nxt;
  logic             cfg_ok;

  // Candidate selection: in-order mode only ever looks at the oldest outstanding entry,
  // any-order mode takes the lowest outstanding entry whose address matches.
  always_comb begin
    logic found;
    found     = 1'b0;
    hit       = 1'b0;
    hit_idx   = '0;
    valid_cnt = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (ent_valid[i]) valid_cnt = valid_cnt + CNT_W'(1);
      if (!found && ent_valid[i] && !ent_matched[i]) begin
        if (IN_ORDER) begin
          found = 1'b1;
          if (ent_addr[i] == Adr) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
          end
        end else if (ent_addr[i] == Adr) begin
          found   = 1'b1;
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end
    end
  end

  assign data_ok   = (ent_data[hit_idx] == WriteData);
  assign match_now = (state == S_RUN) && MemWrite && hit && data_ok;
  assign mism_now  = (state == S_RUN) && MemWrite && hit && !data_ok;
  assign cnt_inc   = match_cnt + CNT_W'(1);
  assign all_done  = match_now && (cnt_inc == valid_cnt);
  assign cyc_nxt   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 32'd1;
  assign tmo_now   = (TIMEOUT_CYCLES != 0) && (cyc_nxt >= TIMEOUT_CYCLES);
  assign cfg_ok    = cfg_we && (int'(cfg_idx) < NUM_CHECKS);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (valid_cnt == '0) ? S_PASS : S_RUN;
      end
      S_RUN: begin
        // A deciding write outranks a timeout landing on the same edge.
        if (mism_now)      state_nxt = S_FAIL;
        else if (all_done) state_nxt = S_PASS;
        else if (tmo_now)  state_nxt = S_FAIL;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_valid   <= '0;
      ent_matched <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      timeout   <= 1'b0;
      fail_idx  <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
`ifdef MEMCHK_CAPTURE_EN
      fail_addr <= '0;
      fail_data <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_ok) begin
            ent_addr[cfg_idx]  <= cfg_addr;
            ent_data[cfg_idx]  <= cfg_data;
            ent_valid[cfg_idx] <= 1'b1;
          end
        end
        S_RUN: begin
          cycle_cnt <= cyc_nxt;
          if (match_now) begin
            ent_matched[hit_idx] <= 1'b1;
            match_cnt            <= cnt_inc;
          end
          if (mism_now) begin
            fail_idx  <= hit_idx;
`ifdef MEMCHK_CAPTURE_EN
            fail_addr <= Adr;
            fail_data <= WriteData;
`endif
          end else if (!all_done && tmo_now) begin
            timeout  <= 1'b1;
            fail_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);
  assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: an in-order and an any-order checker share one stimulus stream, timeout 50.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        start;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;

  logic        o_busy, o_done, o_pass, o_fail, o_tmo;
  logic [1:0]  o_fidx;
  logic [2:0]  o_mcnt;
  logic [31:0] o_cyc;
  logic        a_busy, a_done, a_pass, a_fail, a_tmo;
  logic [1:0]  a_fidx;
  logic [2:0]  a_mcnt;
  logic [31:0] a_cyc;
`ifdef MEMCHK_CAPTURE_EN
  logic [31:0] o_faddr, o_fdata, a_faddr, a_fdata;
`endif

  mem_write_checker #(.NUM_CHECKS(4), .TIMEOUT_CYCLES(50), .IN_ORDER(1'b1)) u_ord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .busy(o_busy), .done(o_done), .pass(o_pass), .fail(o_fail), .timeout(o_tmo),
    .fail_idx(o_fidx), .match_cnt(o_mcnt), .cycle_cnt(o_cyc)
`ifdef MEMCHK_CAPTURE_EN
    , .fail_addr(o_faddr), .fail_data(o_fdata)
`endif
  );

  mem_write_checker #(.NUM_CHECKS(4), .TIMEOUT_CYCLES(50), .IN_ORDER(1'b0)) u_any (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tmo),
    .fail_idx(a_fidx), .match_cnt(a_mcnt), .cycle_cnt(a_cyc)
`ifdef MEMCHK_CAPTURE_EN
    , .fail_addr(a_faddr), .fail_data(a_fdata)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; MemWrite = 1'b0; Adr = '0; WriteData = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic load_std();
    load(2'd0, 32'd100, 32'h0689_0000);
    load(2'd1, 32'd104, 32'h01B0_2B93);
    load(2'd2, 32'd108, 32'hE373_0400);
    load(2'd3, 32'd112, 32'hFFFF_FFFF);
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    step();
    MemWrite = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst busy", 32'(o_busy), 0);
    check("rst done", 32'(o_done), 0);
    check("rst pass", 32'(o_pass), 0);
    check("rst fail", 32'(o_fail), 0);
    check("rst timeout", 32'(o_tmo), 0);
    check("rst match_cnt", 32'(o_mcnt), 0);
    check("rst cycle_cnt", o_cyc, 0);

    // In-order pass
    load_std();
    go();
    check("s1 busy", 32'(o_busy), 1);
    wr(32'd100, 32'h0689_0000);
    wr(32'd104, 32'h01B0_2B93);
    wr(32'd108, 32'hE373_0400);
    check("s1 mid match_cnt", 32'(o_mcnt), 3);
    check("s1 mid pass", 32'(o_pass), 0);
    wr(32'd112, 32'hFFFF_FFFF);
    check("s1 pass", 32'(o_pass), 1);
    check("s1 done", 32'(o_done), 1);
    check("s1 fail", 32'(o_fail), 0);
    check("s1 busy", 32'(o_busy), 0);
    check("s1 match_cnt", 32'(o_mcnt), 4);
    check("s1 cycle_cnt", o_cyc, 4);
    check("s1 any pass", 32'(a_pass), 1);
    go();
    step();
    check("s1 start ignored pass", 32'(o_pass), 1);
    check("s1 frozen cycle_cnt", o_cyc, 4);

    // Data mismatch on entry 1
    do_reset();
    load_std();
    go();
    wr(32'd100, 32'h0689_0000);
    wr(32'd104, 32'h01B0_2B94);
    check("s2 fail", 32'(o_fail), 1);
    check("s2 done", 32'(o_done), 1);
    check("s2 fail_idx", 32'(o_fidx), 1);
    check("s2 timeout", 32'(o_tmo), 0);
    check("s2 match_cnt", 32'(o_mcnt), 1);
    check("s2 any fail_idx", 32'(a_fidx), 1);
`ifdef MEMCHK_CAPTURE_EN
    check("s2 fail_addr", o_faddr, 32'd104);
    check("s2 fail_data", o_fdata, 32'h01B0_2B94);
`endif
    wr(32'd108, 32'hE373_0400);
    check("s2 held fail_idx", 32'(o_fidx), 1);

    // Out-of-order writes with unlisted traffic to 0x20
    do_reset();
    load_std();
    go();
    wr(32'd112, 32'hFFFF_FFFF);
    wr(32'h20, 32'h1234_5678);
    wr(32'd100, 32'h0689_0000);
    wr(32'h20, 32'hDEAD_BEEF);
    wr(32'd108, 32'hE373_0400);
    wr(32'h20, 32'h0);
    wr(32'd104, 32'h01B0_2B93);
    check("s3 any pass", 32'(a_pass), 1);
    check("s3 any match_cnt", 32'(a_mcnt), 4);
    check("s3 ord pass", 32'(o_pass), 0);
    check("s3 ord fail", 32'(o_fail), 0);
    check("s3 ord busy", 32'(o_busy), 1);
    check("s3 ord match_cnt", 32'(o_mcnt), 2);
    check("s3 ord cycle_cnt", o_cyc, 7);

    // Timeout with no matching writes
    do_reset();
    load_std();
    go();
    repeat (49) step();
    check("s4 pre fail", 32'(o_fail), 0);
    check("s4 pre cycle_cnt", o_cyc, 49);
    step();
    check("s4 fail", 32'(o_fail), 1);
    check("s4 timeout", 32'(o_tmo), 1);
    check("s4 fail_idx", 32'(o_fidx), 0);
    check("s4 cycle_cnt", o_cyc, 50);
`ifdef MEMCHK_CAPTURE_EN
    check("s4 fail_addr", o_faddr, 0);
`endif
    repeat (3) step();
    check("s4 frozen cycle_cnt", o_cyc, 50);

    // Reset mid-RUN after two matches, then start on a cleared table
    do_reset();
    load_std();
    go();
    wr(32'd100, 32'h0689_0000);
    wr(32'd104, 32'h01B0_2B93);
    check("s5 match_cnt", 32'(o_mcnt), 2);
    do_reset();
    check("s5 busy", 32'(o_busy), 0);
    check("s5 done", 32'(o_done), 0);
    check("s5 match_cnt", 32'(o_mcnt), 0);
    check("s5 cycle_cnt", o_cyc, 0);
    go();
    check("s5 empty pass", 32'(o_pass), 1);
    check("s5 empty any pass", 32'(a_pass), 1);

    // cfg_we in RUN ignored; final match lands exactly on the timeout cycle
    do_reset();
    load_std();
    go();
    load(2'd0, 32'h55, 32'h0);
    repeat (45) step();
    check("s6 cycle_cnt", o_cyc, 46);
    wr(32'd100, 32'h0689_0000);
    wr(32'd104, 32'h01B0_2B93);
    wr(32'd108, 32'hE373_0400);
    wr(32'd112, 32'hFFFF_FFFF);
    check("s6 pass", 32'(o_pass), 1);
    check("s6 fail", 32'(o_fail), 0);
    check("s6 timeout", 32'(o_tmo), 0);
    check("s6 cycle_cnt", o_cyc, 50);
    check("s6 any pass", 32'(a_pass), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
